// File: rtl/vga_sync_rx.sv
// vga_sync_rx: recovers VGA raster timing from sampled hsync/vsync, locks to the nominal raster and emits x/y plus a qualified pixel stream.
// Optional VGA_RX_CHECKSUM_EN adds frame_sum, the per-frame sum of valid pixels.
module vga_sync_rx #(
    parameter logic [10:0] H_TOTAL     = 11'd800,
    parameter logic [9:0]  V_TOTAL     = 10'd525,
    parameter logic [10:0] H_OFFSET    = 11'd144,
    parameter logic [9:0]  V_OFFSET    = 10'd35,
    parameter logic [10:0] H_ACTIVE    = 11'd640,
    parameter logic [9:0]  V_ACTIVE    = 10'd480,
    parameter logic [3:0]  LOCK_FRAMES = 4'd2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] rgb_in,
    output logic [11:0] pixel,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        pixel_valid,
    output logic        frame_start,
    output logic        locked,
    output logic [10:0] line_len,
    output logic [9:0]  frame_lines
`ifdef VGA_RX_CHECKSUM_EN
    ,
    output logic [15:0] frame_sum
`endif
);
    localparam logic [1:0] SEARCH = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2;
    localparam logic [10:0] H_LOSS = 11'(2 * H_TOTAL);
    logic [2:0] hs_sh, vs_sh;
    logic [11:0] rgb_d1, rgb_d2, rgb_d3;
    logic [10:0] h_cnt, len_now;
    logic [9:0] v_cnt, lines_now;
    logic [1:0] state, state_nxt;
    logic [3:0] good_cnt, good_nxt;
    logic vs_pend, bad, hs_fe, vs_fe, bnd, line_bad, frame_bad, frame_ok, in_win;
    // Sync flops idle high so the first low level after reset reads as a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_sh  <= 3'b111;
            vs_sh  <= 3'b111;
            rgb_d1 <= '0;
            rgb_d2 <= '0;
            rgb_d3 <= '0;
        end else begin
            hs_sh  <= {hs_sh[1:0], hsync};
            vs_sh  <= {vs_sh[1:0], vsync};
            rgb_d1 <= rgb_in;
            rgb_d2 <= rgb_d1;
            rgb_d3 <= rgb_d2;
        end
    end
    assign hs_fe     = hs_sh[2] & ~hs_sh[1];
    assign vs_fe     = vs_sh[2] & ~vs_sh[1];
    assign len_now   = h_cnt + 11'd1;
    assign lines_now = v_cnt + 10'd1;
    assign bnd       = hs_fe & (vs_pend | vs_fe);
    assign line_bad  = hs_fe & (len_now != H_TOTAL);
    assign frame_bad = bad | line_bad;
    assign frame_ok  = !frame_bad && lines_now == V_TOTAL;
    assign in_win    = h_cnt >= H_OFFSET && h_cnt < H_OFFSET + H_ACTIVE &&
                       v_cnt >= V_OFFSET && v_cnt < V_OFFSET + V_ACTIVE;
    assign locked    = state == LOCKED;
    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        if (state == SEARCH) begin
            if (bnd) begin
                state_nxt = ACQUIRE;
                good_nxt  = '0;
            end
        end else if (state == ACQUIRE) begin
            if (bnd) begin
                good_nxt  = frame_ok ? good_cnt + 4'd1 : 4'd0;
                state_nxt = frame_ok && good_cnt + 4'd1 >= LOCK_FRAMES ? LOCKED : ACQUIRE;
            end
        end else if (line_bad || (bnd && lines_now != V_TOTAL) || h_cnt >= H_LOSS) begin
            state_nxt = SEARCH;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            vs_pend     <= 1'b0;
            bad         <= 1'b0;
            state       <= SEARCH;
            good_cnt    <= '0;
            line_len    <= '0;
            frame_lines <= '0;
            frame_start <= 1'b0;
            pixel_valid <= 1'b0;
            x           <= '0;
            y           <= '0;
            pixel       <= '0;
        end else begin
            h_cnt       <= hs_fe ? 11'd0 : (&h_cnt ? h_cnt : len_now);
            line_len    <= hs_fe ? len_now : line_len;
            v_cnt       <= bnd ? 10'd0 : (hs_fe ? lines_now : v_cnt);
            frame_lines <= bnd ? lines_now : frame_lines;
            vs_pend     <= bnd ? 1'b0 : (vs_pend | vs_fe);
            bad         <= bnd ? 1'b0 : frame_bad;
            state       <= state_nxt;
            good_cnt    <= good_nxt;
            frame_start <= bnd;
            pixel_valid <= state_nxt == LOCKED && in_win;
            x           <= in_win ? 10'(h_cnt - H_OFFSET) : 10'd0;
            y           <= in_win ? v_cnt - V_OFFSET : 10'd0;
            pixel       <= rgb_d3;
        end
    end
`ifdef VGA_RX_CHECKSUM_EN
    logic [15:0] acc;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            frame_sum <= '0;
        end else begin
            acc       <= bnd ? 16'd0 : (pixel_valid ? acc + {4'd0, pixel} : acc);
            frame_sum <= bnd ? acc : frame_sum;
        end
    end
`endif
endmodule

// File: doc/vga_sync_rx.md
# vga_sync_rx

Receive-side VGA timing recovery block; the sink-end counterpart of the 640x480 sync generator. Samples incoming hsync/vsync/rgb in the 25 MHz pixel clock domain, measures line and frame length, locks to the nominal 800x525 raster, and regenerates x/y coordinates plus a qualified pixel stream. Used for loopback checking of the display path and as the front end of frame-capture logic.

## Interface
- H_TOTAL, 800: expected pixel clocks per line
- V_TOTAL, 525: expected lines per frame
- H_OFFSET, 144: clocks from hsync falling edge to first active pixel (sync + back porch)
- V_OFFSET, 35: lines from frame start to first active line
- H_ACTIVE, 640 / V_ACTIVE, 480: active window size
- LOCK_FRAMES, 2: consecutive good frames required to lock
- clk  in  1  pixel clock, 25 MHz; all logic on rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- hsync  in  1  active-low horizontal sync, asynchronous to clk
- vsync  in  1  active-low vertical sync, asynchronous to clk
- rgb_in  in  12  pixel data, {R[3:0],G[3:0],B[3:0]}
- pixel  out  12  rgb_in, delayed to align with x/y
- x  out  10  active-area column, 0..H_ACTIVE-1
- y  out  10  active-area row, 0..V_ACTIVE-1
- pixel_valid  out  1  high when locked and inside active window
- frame_start  out  1  one-cycle pulse at each evaluated frame boundary
- locked  out  1  raster lock indicator
- line_len  out  11  last measured line length in clocks
- frame_lines  out  10  last measured frame length in lines

## Operation
- Input path: hsync, vsync, rgb_in through 2-flop synchronizers, then an edge register; falling edge flags hs_fe/vs_fe valid 3 cycles after pin change. rgb delayed identically.
- h_cnt (11b): cleared to 0 on hs_fe, else +1, saturating at 2047. On hs_fe, line_len <= h_cnt+1 (800-clock line captures 800).
- vs_fe sets vs_pend. v_cnt (10b): +1 on hs_fe; on hs_fe with vs_pend (including same-cycle vs_fe), v_cnt <= 0, frame_lines <= v_cnt+1, vs_pend cleared, frame_start pulses: the frame boundary event.
- bad flag: set on hs_fe with captured length != H_TOTAL, cleared at frame boundary after evaluation.
- FSM states SEARCH, ACQUIRE, LOCKED:
  - SEARCH -> ACQUIRE at first frame boundary, good_cnt <= 0.
  - ACQUIRE: at each boundary, if !bad and frame_lines == V_TOTAL then good_cnt+1, else good_cnt <= 0; good_cnt reaching LOCK_FRAMES -> LOCKED.
  - LOCKED -> SEARCH on any bad line length (at that hs_fe), on frame length mismatch at a boundary, or on h_cnt reaching 2*H_TOTAL (signal loss).
- pixel_valid = locked && H_OFFSET <= h_cnt < H_OFFSET+H_ACTIVE && V_OFFSET <= v_cnt < V_OFFSET+V_ACTIVE; x = h_cnt-H_OFFSET, y = v_cnt-V_OFFSET; outside window x, y hold 0.

## Timing
- Reset values: pixel 0, x 0, y 0, pixel_valid 0, frame_start 0, locked 0, line_len 0, frame_lines 0, state SEARCH, vs_pend 0.
- Outputs registered; pixel/x/y/pixel_valid appear 1 cycle after counter state, 4 cycles after pin.
- locked asserts the cycle after the boundary that completes LOCK_FRAMES; deasserts the cycle after the failing event; pixel_valid drops the same cycle.
- Reset asserted mid-frame: immediate clear; after release, lock requires a fresh SEARCH/ACQUIRE sequence.

## Configuration
- VGA_RX_CHECKSUM_EN defined: adds output frame_sum [15:0], modulo-2^16 sum of pixel over all pixel_valid cycles of a frame, latched at frame boundary, reset 0; accumulator clears at boundary.
- Undefined: port and accumulator absent; all other behaviour identical.

## Test plan
- Nominal 800x525 raster from sync generator, LOCK_FRAMES=2 -> locked rises 1 cycle after third frame boundary; line_len=800, frame_lines=525.
- Locked, white active area -> pixel_valid high exactly 640x480 cycles per frame, first at x=0,y=0 and last at x=639,y=479, pixel=12'hFFF.
- Locked, one line shortened to 799 clocks -> locked and pixel_valid low 1 cycle after that hsync edge; relock after two further good frames.
- hsync held high 1600 clocks while locked -> locked drops at h_cnt=1600; h_cnt saturates at 2047.
- vsync and hsync falling edges in same cycle -> single frame boundary, frame_lines=525, v_cnt=0, one frame_start pulse.
- VGA_RX_CHECKSUM_EN defined, constant 12'h001 active pixels -> frame_sum = 307200 mod 65536 = 16'hB000.
